// File: rtl/audio_sample_player.sv
// PCM player: pulls one byte per sample period from the sector FIFO, attenuates it,
// and drives a 4-bit DAC through first-order error-feedback noise shaping.
//   state    | meaning
//   ST_WAIT  | idle, waiting for sample_tick
//   ST_FETCH | Lesen high, FIFO dequeues this cycle
//   ST_LATCH | Daten valid, capture it into sample
module audio_sample_player #(
   parameter int unsigned CLK_FREQ    = 25_000_000,
   parameter int unsigned SAMPLE_RATE = 32_000,
   parameter int unsigned VOL_RESET   = 2
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [7:0]  Daten,
   input  logic        fifo_empty,
   input  logic        vol_up,
   input  logic        vol_down,
   input  logic        pause_btn,
   output logic        Lesen,
   output logic [3:0]  audio_l,
   output logic [3:0]  audio_r,
   output logic        sample_tick,
   output logic        playing,
   output logic [2:0]  volume,
   output logic [15:0] underrun_count
);

   localparam logic [31:0] PHASE_INC = 32'(SAMPLE_RATE);
   localparam logic [31:0] PHASE_MOD = 32'(CLK_FREQ);
   localparam logic [2:0]  VOL_INIT  = 3'(VOL_RESET);

   typedef enum logic [1:0] {ST_WAIT, ST_FETCH, ST_LATCH} state_t;

   state_t      state, state_nxt;
   logic        lesen_nxt;
   logic [7:0]  sample, sample_nxt;
   logic [15:0] underrun_nxt;
   logic [31:0] phase, phase_sum;
   logic [2:0]  up_sync, dn_sync, pb_sync;
   logic        up_rise, dn_rise, pb_rise;
   logic signed [7:0] s_val, a_val;
   logic [7:0]  dac_in;
   logic [3:0]  err;
   logic [8:0]  ns_sum;

   assign phase_sum = phase + PHASE_INC;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         phase       <= '0;
         sample_tick <= 1'b0;
      end else if (phase_sum >= PHASE_MOD) begin
         phase       <= phase_sum - PHASE_MOD;
         sample_tick <= 1'b1;
      end else begin
         phase       <= phase_sum;
         sample_tick <= 1'b0;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state          <= ST_WAIT;
         Lesen          <= 1'b0;
         sample         <= 8'h80;
         underrun_count <= '0;
      end else begin
         state          <= state_nxt;
         Lesen          <= lesen_nxt;
         sample         <= sample_nxt;
         underrun_count <= underrun_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      lesen_nxt    = 1'b0;
      sample_nxt   = sample;
      underrun_nxt = underrun_count;
      case (state)
         ST_WAIT: begin
            if (sample_tick) begin
               if (!playing) begin
                  sample_nxt = 8'h80;
               end else if (fifo_empty) begin
                  sample_nxt = 8'h80;
                  if (underrun_count != 16'hFFFF) underrun_nxt = underrun_count + 16'd1;
               end else begin
                  lesen_nxt = 1'b1;
                  state_nxt = ST_FETCH;
               end
            end
         end
         ST_FETCH: state_nxt = ST_LATCH;
         ST_LATCH: begin
            sample_nxt = Daten;
            state_nxt  = ST_WAIT;
         end
         default: state_nxt = ST_WAIT;
      endcase
   end

   // bits [1:0] synchronize, bit [2] holds the previous level for edge detection
   always_ff @(posedge Clock) begin
      if (Reset) begin
         up_sync <= '0;
         dn_sync <= '0;
         pb_sync <= '0;
      end else begin
         up_sync <= {up_sync[1:0], vol_up};
         dn_sync <= {dn_sync[1:0], vol_down};
         pb_sync <= {pb_sync[1:0], pause_btn};
      end
   end

   assign up_rise = up_sync[1] & ~up_sync[2];
   assign dn_rise = dn_sync[1] & ~dn_sync[2];
   assign pb_rise = pb_sync[1] & ~pb_sync[2];

   always_ff @(posedge Clock) begin
      if (Reset) begin
         volume  <= VOL_INIT;
         playing <= 1'b1;
      end else begin
         if (up_rise && !dn_rise && volume != 3'd0)
            volume <= volume - 3'd1;
         else if (dn_rise && !up_rise && volume != 3'd7)
            volume <= volume + 3'd1;
         if (pb_rise) playing <= ~playing;
      end
   end

   // sample-128 always fits in 8 signed bits, so the offset is just an MSB flip
   assign s_val  = $signed({~sample[7], sample[6:0]});
   assign a_val  = s_val >>> volume;
   assign dac_in = {~a_val[7], a_val[6:0]};
   assign ns_sum = {1'b0, dac_in} + {5'b0, err};

   always_ff @(posedge Clock) begin
      if (Reset) begin
         err     <= '0;
         audio_l <= 4'h8;
      end else begin
         err     <= ns_sum[3:0];
         audio_l <= ns_sum[8] ? 4'hF : ns_sum[7:4];
      end
   end

   assign audio_r = audio_l;

endmodule

// File: tb/tb_audio_sample_player.sv
// Scoreboard bench for audio_sample_player: per-tick expectations from a behavioural model,
// checked by an independent monitor against Lesen, counters and the 16-cycle audio mean.
module tb_audio_sample_player;

   localparam int CF    = 250_000;
   localparam int SR    = 3_200;
   localparam int N_CNT = 10_000;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic [7:0]  Daten = 8'h00;
   logic        fifo_empty = 1'b0;
   logic        vol_up = 1'b0, vol_down = 1'b0, pause_btn = 1'b0;
   logic        Lesen, sample_tick, playing;
   logic [3:0]  audio_l, audio_r;
   logic [2:0]  volume;
   logic [15:0] underrun_count;

   audio_sample_player #(.CLK_FREQ(CF), .SAMPLE_RATE(SR), .VOL_RESET(2)) dut (
      .Clock(Clock), .Reset(Reset), .Daten(Daten), .fifo_empty(fifo_empty),
      .vol_up(vol_up), .vol_down(vol_down), .pause_btn(pause_btn),
      .Lesen(Lesen), .audio_l(audio_l), .audio_r(audio_r), .sample_tick(sample_tick),
      .playing(playing), .volume(volume), .underrun_count(underrun_count));

   always #5 Clock = ~Clock;

   typedef struct {
      bit rd;
      int dac;
      int ur;
      bit play;
      int vol;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] fifo_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;
   bit  sb_on    = 1'b0;
   int  m_vol    = 2;
   bit  m_play   = 1'b1;
   int  m_ur     = 0;

   task automatic chk(input string nm, input longint act, input longint expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
      end
   endtask

   // signed floor division by 2^v, then re-centre at 128
   function automatic int vol_model(input int b, input int v);
      int s, d, a;
      s = b - 128;
      d = 1 << v;
      if (s >= 0) a = s / d;
      else        a = -((-s + d - 1) / d);
      return a + 128;
   endfunction

   task automatic press(input int a);
      if (a == 1 || a == 3) vol_up = 1'b1;
      if (a == 2 || a == 3) vol_down = 1'b1;
      if (a == 4) pause_btn = 1'b1;
      repeat (4) @(negedge Clock);
      vol_up = 1'b0; vol_down = 1'b0; pause_btn = 1'b0;
      repeat (4) @(negedge Clock);
      if (a == 1 && m_vol > 0) m_vol--;
      if (a == 2 && m_vol < 7) m_vol++;
      if (a == 4) m_play = !m_play;
   endtask

   // FIFO responder: one byte per Lesen pulse, presented in the following cycle
   initial forever begin
      @(negedge Clock);
      if (Lesen === 1'b1) Daten = (fifo_q.size() > 0) ? fifo_q.pop_front() : 8'hA5;
   end

   int tick_cnt = 0;
   initial begin
      wait (Reset == 1'b0);
      repeat (N_CNT) begin
         @(negedge Clock);
         if (sample_tick) tick_cnt++;
      end
      chk("tick_count", tick_cnt, (longint'(N_CNT) * SR) / CF);
   end

   int   lc, asum, rdiff;
   exp_t me;
   initial forever begin
      @(negedge Clock);
      if (sb_on && sample_tick) begin
         lc = 0; asum = 0; rdiff = 0;
         repeat (4) begin
            @(negedge Clock);
            if (Lesen) lc++;
         end
         if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL sb_empty: tick with no expectation queued");
         end else begin
            me = exp_q.pop_front();
            chk("lesen_pulses", lc, me.rd);
            chk("underrun_count", underrun_count, me.ur);
            chk("playing", playing, me.play);
            chk("volume", volume, me.vol);
            repeat (2) @(negedge Clock);
            repeat (16) begin
               @(negedge Clock);
               asum += audio_l;
               if (audio_r !== audio_l) rdiff++;
            end
            if (me.dac <= 240) chk("audio_sum16", asum, me.dac);
            chk("audio_r_eq_l", rdiff, 0);
         end
      end
   end

   int   wt, cur_byte, act, reps, bad;
   bit   nxt_empty;
   exp_t e;
   initial begin
      repeat (4) @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
      chk("rst_lesen", Lesen, 0);
      chk("rst_tick", sample_tick, 0);
      chk("rst_playing", playing, 1);
      chk("rst_volume", volume, 2);
      chk("rst_underrun", underrun_count, 0);
      chk("rst_audio_l", audio_l, 8);
      chk("rst_audio_r", audio_r, 8);
      sb_on = 1'b1;

      for (int t = 0; t < 130; t++) begin
         wt = 0;
         do begin
            @(negedge Clock);
            wt++;
         end while (!sample_tick && wt < 300);
         if (!sample_tick) begin
            n_checks++; n_fail++;
            $display("FAIL tick_timeout: no sample_tick within %0d cycles", wt);
            break;
         end
         nxt_empty = 1'b0; act = 0; reps = 0;
         cur_byte = $urandom_range(0, 255);
         case (t)
            0: begin cur_byte = 'hC0; act = 2; reps = 3; end
            1: begin cur_byte = 'h40; act = 2; reps = 4; end
            2: begin cur_byte = 'h00; act = 2; reps = 2; end
            3: begin cur_byte = 'hFF; act = 1; reps = 4; end
            4: begin cur_byte = 'hC0; act = 1; reps = 3; end
            5: begin cur_byte = 'hC0; act = 3; reps = 2; end
            6: begin cur_byte = 'h11; act = 1; reps = 1; end
            7: begin cur_byte = 'hE0; nxt_empty = 1'b1; end
            8, 9, 10, 11: nxt_empty = 1'b1;
            13: begin cur_byte = 'h5A; act = 4; reps = 1; end
            33: begin act = 4; reps = 1; end
            default: if (t >= 34) begin
               nxt_empty = ($urandom_range(0, 4) == 0);
               act  = $urandom_range(0, 6);
               if (act > 4) act = 0;
               reps = $urandom_range(1, 3);
            end
         endcase
         e.play = m_play;
         e.vol  = m_vol;
         if (!m_play) begin
            e.rd = 1'b0; e.dac = 128;
         end else if (fifo_empty) begin
            e.rd = 1'b0; e.dac = 128;
            if (m_ur < 65535) m_ur++;
         end else begin
            e.rd = 1'b1; e.dac = vol_model(cur_byte, m_vol);
            fifo_q.push_back(8'(cur_byte));
         end
         e.ur = m_ur;
         exp_q.push_back(e);
         repeat (25) @(negedge Clock);
         for (int r = 0; r < reps; r++) press(act);
         fifo_empty = nxt_empty;
      end

      sb_on = 1'b0;
      repeat (30) @(negedge Clock);
      fifo_empty = 1'b0;
      if (!m_play) press(4);
      wt = 0;
      do begin
         @(negedge Clock);
         wt++;
      end while (Lesen !== 1'b1 && wt < 300);
      if (Lesen !== 1'b1) begin
         n_checks++; n_fail++;
         $display("FAIL fetch_timeout: no Lesen within %0d cycles", wt);
      end else begin
         Reset = 1'b1;
         @(negedge Clock);
         chk("mid_lesen", Lesen, 0);
         chk("mid_tick", sample_tick, 0);
         chk("mid_playing", playing, 1);
         chk("mid_volume", volume, 2);
         chk("mid_underrun", underrun_count, 0);
         chk("mid_audio", audio_l, 8);
         Reset = 1'b0;
         bad = 0;
         repeat (20) begin
            @(negedge Clock);
            if (audio_l != 4'h8 || Lesen) bad++;
         end
         chk("post_reset_idle", bad, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
